// File: rtl/fc_seq_pkg.sv
// fc_seq_pkg: shared types and constants for the FC layer sequencer.
//   - seq_state_t : sequencer FSM states
//   - desc_t      : per-layer descriptor (channel counts, bias flag,
//                   activation, input/weight/output base addresses)
//   - CH_W, ADDR_W, ACT_W, DESC_W : field and descriptor widths
package fc_seq_pkg;

   localparam int CH_W   = 12;
   localparam int ADDR_W = 27;
   localparam int ACT_W  = 5;

   typedef enum logic [3:0] {
      IDLE,
      LOAD,
      ISSUE_LIF,
      WAIT_LIF,
      ISSUE_LW,
      WAIT_LW,
      ISSUE_SOF,
      WAIT_SOF,
      NEXT,
      FINISH
   } seq_state_t;

   typedef struct packed {
      logic [CH_W-1:0]   cin;
      logic [CH_W-1:0]   cout;
      logic              has_bias;
      logic [ACT_W-1:0]  act;
      logic [ADDR_W-1:0] in_addr;
      logic [ADDR_W-1:0] w_addr;
      logic [ADDR_W-1:0] out_addr;
   } desc_t;

   localparam int DESC_W = $bits(desc_t);

   // Builds a descriptor from its fields, in struct field order.
   function automatic desc_t make_desc(
      input logic [CH_W-1:0]   cin,
      input logic [CH_W-1:0]   cout,
      input logic              has_bias,
      input logic [ACT_W-1:0]  act,
      input logic [ADDR_W-1:0] in_addr,
      input logic [ADDR_W-1:0] w_addr,
      input logic [ADDR_W-1:0] out_addr
   );
      desc_t d;
      d.cin      = cin;
      d.cout     = cout;
      d.has_bias = has_bias;
      d.act      = act;
      d.in_addr  = in_addr;
      d.w_addr   = w_addr;
      d.out_addr = out_addr;
      return d;
   endfunction

endpackage

// File: rtl/fc_seq_desc_ram.sv
// fc_seq_desc_ram: single-port descriptor table, synchronous read and
// write, no reset (contents survive a sequencer reset).
// Ports:
//   clk   in   clock
//   we    in   write enable (writes wdata to addr)
//   addr  in   shared read/write address
//   wdata in   descriptor to write
//   rdata out  registered read data; on a write it returns the data
//              being written (write-first)
module fc_seq_desc_ram
   import fc_seq_pkg::*;
#(
   parameter int DEPTH = 16,
   parameter int AW    = 4
) (
   input  logic              clk,
   input  logic              we,
   input  logic [AW-1:0]     addr,
   input  logic [DESC_W-1:0] wdata,
   output logic [DESC_W-1:0] rdata
);

   logic [DESC_W-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) begin
         mem[addr] <= wdata;
         rdata     <= wdata;
      end else begin
         rdata <= mem[addr];
      end
   end

endmodule

// File: rtl/fc_layer_sequencer.sv
// fc_layer_sequencer: walks the FC data loader through a multi-layer
// fully-connected network. For each layer it issues input-feature load
// (LIF), weight/bias load (LW) and output store (SOF), waiting for the
// loader's done between steps.
// Optional feature: define FC_SEQ_WDOG_EN to add a watchdog on every WAIT
// state (parameter WDOG_CYCLES); when it expires the run aborts with err.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   cfg_we, cfg_idx, cfg_*   descriptor table write port (ignored while busy)
//   num_layers, start        run request; num_layers sampled with start
//   busy, done, err          run status (done/err are one-cycle pulses)
//   cur_layer                layer currently executing
//   cin, cout, has_bias,
//   act_type, base_addr      loader configuration
//   lif_start, lw_start,
//   sof_start                loader step starts (one-cycle pulses)
//   ldr_done                 loader step complete
// Handshake: each *_start is a one-cycle request; the loader answers with a
// one-cycle ldr_done, accepted only in the matching WAIT state.
module fc_layer_sequencer
   import fc_seq_pkg::*;
#(
   parameter int MAX_LAYERS = 16
`ifdef FC_SEQ_WDOG_EN
   ,
   parameter int WDOG_CYCLES = 1 << 20
`endif
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cfg_we,
   input  logic [3:0]        cfg_idx,
   input  logic [11:0]       cfg_cin,
   input  logic [11:0]       cfg_cout,
   input  logic              cfg_has_bias,
   input  logic [4:0]        cfg_act,
   input  logic [26:0]       cfg_in_addr,
   input  logic [26:0]       cfg_w_addr,
   input  logic [26:0]       cfg_out_addr,
   input  logic [4:0]        num_layers,
   input  logic              start,
   output logic              busy,
   output logic              done,
   output logic              err,
   output logic [3:0]        cur_layer,
   output logic [11:0]       cin,
   output logic [11:0]       cout,
   output logic              has_bias,
   output logic [4:0]        act_type,
   output logic [26:0]       base_addr,
   output logic              lif_start,
   output logic              lw_start,
   output logic              sof_start,
   input  logic              ldr_done
);

   localparam logic [4:0] MAX_L = 5'(MAX_LAYERS);

   seq_state_t        state;
   logic [4:0]        layer_cnt;
   logic              desc_ok;
   logic [ADDR_W-1:0] w_addr_q;
   logic [ADDR_W-1:0] out_addr_q;

   logic              ram_we;
   logic [3:0]        ram_addr;
   logic [DESC_W-1:0] ram_wdata;
   logic [DESC_W-1:0] ram_rdata;
   desc_t             rd;
   logic              last_layer;

   // The table may only change while no run is in progress.
   assign ram_we    = cfg_we && !busy;
   assign ram_wdata = make_desc(cfg_cin, cfg_cout, cfg_has_bias, cfg_act,
                                cfg_in_addr, cfg_w_addr, cfg_out_addr);
   assign rd        = desc_t'(ram_rdata);
   assign last_layer = (({1'b0, cur_layer} + 5'd1) == layer_cnt);

   // The read is launched one cycle ahead of LOAD so LOAD sees valid data:
   // from IDLE for layer 0, from NEXT for the following layer.
   always_comb begin
      ram_addr = cur_layer;
      if (ram_we) begin
         ram_addr = cfg_idx;
      end else if (state == IDLE) begin
         ram_addr = 4'd0;
      end else if (state == NEXT) begin
         ram_addr = cur_layer + 4'd1;
      end
   end

   fc_seq_desc_ram #(
      .DEPTH (MAX_LAYERS),
      .AW    (4)
   ) u_desc_ram (
      .clk   (clk),
      .we    (ram_we),
      .addr  (ram_addr),
      .wdata (ram_wdata),
      .rdata (ram_rdata)
   );

`ifdef FC_SEQ_WDOG_EN
   localparam logic [19:0] WDOG_LAST = 20'(WDOG_CYCLES - 1);
   logic [19:0] wdog_cnt;
   logic        in_wait;
   logic        wdog_fire;
   assign in_wait   = (state == WAIT_LIF) || (state == WAIT_LW) || (state == WAIT_SOF);
   assign wdog_fire = in_wait && !ldr_done && (wdog_cnt == WDOG_LAST);
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         layer_cnt  <= '0;
         desc_ok    <= 1'b0;
         w_addr_q   <= '0;
         out_addr_q <= '0;
         busy       <= 1'b0;
         done       <= 1'b0;
         err        <= 1'b0;
         cur_layer  <= '0;
         cin        <= '0;
         cout       <= '0;
         has_bias   <= 1'b0;
         act_type   <= '0;
         base_addr  <= '0;
         lif_start  <= 1'b0;
         lw_start   <= 1'b0;
         sof_start  <= 1'b0;
`ifdef FC_SEQ_WDOG_EN
         wdog_cnt   <= '0;
`endif
      end else begin
         done      <= 1'b0;
         err       <= 1'b0;
         lif_start <= 1'b0;
         lw_start  <= 1'b0;
         sof_start <= 1'b0;

         case (state)
            IDLE: begin
               if (start) begin
                  if (num_layers == 5'd0) begin
                     // Empty run: report completion without touching the loader.
                     done  <= 1'b1;
                     state <= FINISH;
                  end else if (num_layers > MAX_L) begin
                     err <= 1'b1;
                  end else begin
                     layer_cnt <= num_layers;
                     cur_layer <= '0;
                     busy      <= 1'b1;
                     // A same-cycle write to another entry steals the read
                     // port, so layer 0 must be reread in LOAD.
                     desc_ok   <= !(ram_we && (cfg_idx != 4'd0));
                     state     <= LOAD;
                  end
               end
            end

            LOAD: begin
               if (desc_ok) begin
                  cin        <= rd.cin;
                  cout       <= rd.cout;
                  has_bias   <= rd.has_bias;
                  act_type   <= rd.act;
                  base_addr  <= rd.in_addr;
                  w_addr_q   <= rd.w_addr;
                  out_addr_q <= rd.out_addr;
                  lif_start  <= 1'b1;
                  state      <= ISSUE_LIF;
               end else begin
                  desc_ok <= 1'b1;
               end
            end

            ISSUE_LIF: state <= WAIT_LIF;

            WAIT_LIF: begin
               if (ldr_done) begin
                  base_addr <= w_addr_q;
                  lw_start  <= 1'b1;
                  state     <= ISSUE_LW;
               end
            end

            ISSUE_LW: state <= WAIT_LW;

            WAIT_LW: begin
               if (ldr_done) begin
                  base_addr <= out_addr_q;
                  sof_start <= 1'b1;
                  state     <= ISSUE_SOF;
               end
            end

            ISSUE_SOF: state <= WAIT_SOF;

            WAIT_SOF: begin
               if (ldr_done) begin
                  state <= NEXT;
               end
            end

            NEXT: begin
               if (last_layer) begin
                  done  <= 1'b1;
                  state <= FINISH;
               end else begin
                  cur_layer <= cur_layer + 4'd1;
                  desc_ok   <= 1'b1;
                  state     <= LOAD;
               end
            end

            FINISH: begin
               busy  <= 1'b0;
               state <= IDLE;
            end

            default: state <= IDLE;
         endcase

`ifdef FC_SEQ_WDOG_EN
         // The counter is zero on the first cycle of every WAIT state since
         // each WAIT is entered from a non-WAIT ISSUE state.
         if (in_wait) begin
            wdog_cnt <= wdog_cnt + 20'd1;
         end else begin
            wdog_cnt <= '0;
         end
         if (wdog_fire) begin
            err   <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
         end
`endif
      end
   end

endmodule

// File: tb/tb_fc_layer_sequencer.sv
`timescale 1ns/1ps
module tb_fc_layer_sequencer;

   localparam int EW = 2 + 4 + 27 + 12 + 12 + 1 + 5;
   localparam logic [1:0] K_LIF = 2'd0;
   localparam logic [1:0] K_LW  = 2'd1;
   localparam logic [1:0] K_SOF = 2'd2;

   // ---------------- clock / reset / DUT ----------------
   logic clk = 1'b0;
   logic rst;
   logic cfg_we;
   logic [3:0] cfg_idx;
   logic [11:0] cfg_cin, cfg_cout;
   logic cfg_has_bias;
   logic [4:0] cfg_act;
   logic [26:0] cfg_in_addr, cfg_w_addr, cfg_out_addr;
   logic [4:0] num_layers;
   logic start;
   logic busy, done, err;
   logic [3:0] cur_layer;
   logic [11:0] cin, cout;
   logic has_bias;
   logic [4:0] act_type;
   logic [26:0] base_addr;
   logic lif_start, lw_start, sof_start;
   logic ldr_done;

   always #5 clk = ~clk;

   fc_layer_sequencer #(
      .MAX_LAYERS (16)
`ifdef FC_SEQ_WDOG_EN
      ,
      .WDOG_CYCLES (64)
`endif
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .cfg_we       (cfg_we),
      .cfg_idx      (cfg_idx),
      .cfg_cin      (cfg_cin),
      .cfg_cout     (cfg_cout),
      .cfg_has_bias (cfg_has_bias),
      .cfg_act      (cfg_act),
      .cfg_in_addr  (cfg_in_addr),
      .cfg_w_addr   (cfg_w_addr),
      .cfg_out_addr (cfg_out_addr),
      .num_layers   (num_layers),
      .start        (start),
      .busy         (busy),
      .done         (done),
      .err          (err),
      .cur_layer    (cur_layer),
      .cin          (cin),
      .cout         (cout),
      .has_bias     (has_bias),
      .act_type     (act_type),
      .base_addr    (base_addr),
      .lif_start    (lif_start),
      .lw_start     (lw_start),
      .sof_start    (sof_start),
      .ldr_done     (ldr_done)
   );

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   initial begin
      forever begin
         @(posedge clk);
         cyc++;
      end
   end

   // ---------------- reference model ----------------
   // Descriptor table as the bench believes it to be.
   logic [11:0] m_cin [16];
   logic [11:0] m_cout [16];
   logic        m_bias [16];
   logic [4:0]  m_act [16];
   logic [26:0] m_in [16];
   logic [26:0] m_w [16];
   logic [26:0] m_out [16];

   function automatic logic [EW-1:0] ev(input logic [1:0] k, input logic [3:0] l,
                                        input logic [26:0] a, input logic [11:0] ci,
                                        input logic [11:0] co, input logic b,
                                        input logic [4:0] ac);
      return {k, l, a, ci, co, b, ac};
   endfunction

   logic [EW-1:0] exp_q [$];
   logic [EW-1:0] obs_q [$];
   int obs_cyc_q [$];
   int ld_done_q [$];
   int done_cnt, err_cnt, busy_cnt, done_cyc, err_cyc, start_cyc;

   // Every layer produces LIF, LW, SOF with the layer's own parameters.
   task automatic build_exp(input int n);
      exp_q.delete();
      for (int l = 0; l < n; l++) begin
         exp_q.push_back(ev(K_LIF, 4'(l), m_in[l],  m_cin[l], m_cout[l], m_bias[l], m_act[l]));
         exp_q.push_back(ev(K_LW,  4'(l), m_w[l],   m_cin[l], m_cout[l], m_bias[l], m_act[l]));
         exp_q.push_back(ev(K_SOF, 4'(l), m_out[l], m_cin[l], m_cout[l], m_bias[l], m_act[l]));
      end
   endtask

   // ---------------- monitor ----------------
   initial begin
      forever begin
         @(negedge clk);
         if (lif_start) begin
            obs_q.push_back(ev(K_LIF, cur_layer, base_addr, cin, cout, has_bias, act_type));
            obs_cyc_q.push_back(cyc);
         end
         if (lw_start) begin
            obs_q.push_back(ev(K_LW, cur_layer, base_addr, cin, cout, has_bias, act_type));
            obs_cyc_q.push_back(cyc);
         end
         if (sof_start) begin
            obs_q.push_back(ev(K_SOF, cur_layer, base_addr, cin, cout, has_bias, act_type));
            obs_cyc_q.push_back(cyc);
         end
         if (done) begin
            done_cnt++;
            done_cyc = cyc;
         end
         if (err) begin
            err_cnt++;
            err_cyc = cyc;
         end
         if (busy) busy_cnt++;
      end
   end

   // ---------------- loader model ----------------
   bit ldr_on = 1'b1;
   bit ldr_rand = 1'b0;
   int ldr_lat = 5;
   int cur_lat;

   initial begin
      ldr_done = 1'b0;
      forever begin
         @(negedge clk);
         ldr_done = 1'b0;
         if (ldr_on && (lif_start || lw_start || sof_start)) begin
            cur_lat = ldr_rand ? int'($urandom_range(1, 6)) : ldr_lat;
            repeat (cur_lat) @(negedge clk);
            ldr_done = 1'b1;
            ld_done_q.push_back(cyc);
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic clear_obs();
      obs_q.delete();
      obs_cyc_q.delete();
      ld_done_q.delete();
      done_cnt = 0;
      err_cnt = 0;
      busy_cnt = 0;
      done_cyc = -1;
      err_cyc = -1;
   endtask

   task automatic write_desc(input int idx, input logic [11:0] ci, input logic [11:0] co,
                             input logic b, input logic [4:0] ac, input logic [26:0] ia,
                             input logic [26:0] wa, input logic [26:0] oa, input bit commit);
      cfg_idx = 4'(idx);
      cfg_cin = ci;
      cfg_cout = co;
      cfg_has_bias = b;
      cfg_act = ac;
      cfg_in_addr = ia;
      cfg_w_addr = wa;
      cfg_out_addr = oa;
      cfg_we = 1'b1;
      if (commit) begin
         m_cin[idx] = ci; m_cout[idx] = co; m_bias[idx] = b; m_act[idx] = ac;
         m_in[idx] = ia; m_w[idx] = wa; m_out[idx] = oa;
      end
      @(negedge clk); #1;
      cfg_we = 1'b0;
   endtask

   task automatic write_random(input int idx);
      write_desc(idx, 12'($urandom_range(1, 4095)), 12'($urandom_range(1, 4095)),
                 1'($urandom), 5'($urandom), 27'($urandom), 27'($urandom), 27'($urandom), 1'b1);
   endtask

   task automatic kick(input int n);
      num_layers = 5'(n);
      start = 1'b1;
      start_cyc = cyc;
      @(negedge clk); #1;
      start = 1'b0;
   endtask

   task automatic wait_end(input int budget, input string name);
      int k;
      k = 0;
      while (done_cnt == 0 && err_cnt == 0 && k < budget) begin
         @(negedge clk); #1;
         k++;
      end
      checks++;
      if (done_cnt == 0 && err_cnt == 0) begin
         errors++;
         $display("FAIL %s: no done/err within %0d cycles (required one of them)", name, budget);
      end
   endtask

   // Scoreboard: start sequence, start-to-start timing and done timing.
   // first_gap: cycles from the start cycle to the first LIF start.
   task automatic drain_scoreboard(input string name, input int first_gap);
      int n, exp_c;
      repeat (4) @(negedge clk);
      #1;
      checks++;
      if (obs_q.size() != exp_q.size()) begin
         errors++;
         $display("FAIL %s start count: got %0d required %0d", name, obs_q.size(), exp_q.size());
      end
      n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
      for (int i = 0; i < n; i++) begin
         checks++;
         if (obs_q[i] !== exp_q[i]) begin
            errors++;
            $display("FAIL %s start %0d: got %h required %h", name, i, obs_q[i], exp_q[i]);
         end
         if (i == 0) exp_c = start_cyc + first_gap;
         else if (ld_done_q.size() >= i) exp_c = ld_done_q[i-1] + ((i % 3 == 0) ? 3 : 1);
         else exp_c = -1;
         checks++;
         if (obs_cyc_q[i] != exp_c) begin
            errors++;
            $display("FAIL %s start %0d cycle: got %0d required %0d", name, i, obs_cyc_q[i], exp_c);
         end
      end
      checks++;
      if (done_cnt != 1 || err_cnt != 0) begin
         errors++;
         $display("FAIL %s pulses: done %0d err %0d required done 1 err 0", name, done_cnt, err_cnt);
      end
      exp_c = (ld_done_q.size() > 0) ? ld_done_q[ld_done_q.size()-1] + 2 : -1;
      checks++;
      if (done_cyc != exp_c) begin
         errors++;
         $display("FAIL %s done cycle: got %0d required %0d", name, done_cyc, exp_c);
      end
      checks++;
      if (busy !== 1'b0) begin
         errors++;
         $display("FAIL %s busy after run: got %b required 0", name, busy);
      end
   endtask

   function automatic logic [EW+16:0] all_outputs();
      return {busy, done, err, cur_layer, cin, cout, has_bias, act_type, base_addr,
              lif_start, lw_start, sof_start};
   endfunction

   // ---------------- tests ----------------
   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(negedge clk);
      #1;
      checks++;
      if (all_outputs() !== '0) begin
         errors++;
         $display("FAIL reset_held outputs: got %h required 0", all_outputs());
      end
      rst = 1'b0;
      @(negedge clk); #1;
      checks++;
      if (all_outputs() !== '0) begin
         errors++;
         $display("FAIL reset_released outputs: got %h required 0", all_outputs());
      end
   endtask

   task automatic test_two_layers();
      write_desc(0, 12'd4, 12'd2, 1'b1, 5'd3, 27'h100, 27'h200, 27'h300, 1'b1);
      write_desc(1, 12'd2, 12'd3, 1'b0, 5'd1, 27'h1400, 27'h1500, 27'h1600, 1'b1);
      ldr_rand = 1'b0;
      ldr_lat = 5;
      build_exp(2);
      clear_obs();
      kick(2);
      checks++;
      if (busy !== 1'b1) begin
         errors++;
         $display("FAIL two_layers busy after start: got %b required 1", busy);
      end
      wait_end(300, "two_layers");
      drain_scoreboard("two_layers", 2);
   endtask

   task automatic test_empty_run();
      clear_obs();
      kick(0);
      wait_end(10, "empty_run");
      repeat (4) @(negedge clk);
      #1;
      // start is sampled at the end of its cycle; the next cycle is FINISH.
      checks++;
      if (done_cyc != start_cyc + 1 || done_cnt != 1) begin
         errors++;
         $display("FAIL empty_run done: cycle %0d count %0d required cycle %0d count 1",
                  done_cyc, done_cnt, start_cyc + 1);
      end
      checks++;
      if (obs_q.size() != 0 || busy_cnt != 0 || err_cnt != 0) begin
         errors++;
         $display("FAIL empty_run side effects: starts %0d busy %0d err %0d required 0 0 0",
                  obs_q.size(), busy_cnt, err_cnt);
      end
   endtask

   task automatic test_too_many();
      clear_obs();
      kick(17);
      wait_end(10, "too_many");
      repeat (4) @(negedge clk);
      #1;
      checks++;
      if (err_cyc != start_cyc + 1 || err_cnt != 1) begin
         errors++;
         $display("FAIL too_many err: cycle %0d count %0d required cycle %0d count 1",
                  err_cyc, err_cnt, start_cyc + 1);
      end
      checks++;
      if (obs_q.size() != 0 || busy_cnt != 0 || done_cnt != 0) begin
         errors++;
         $display("FAIL too_many side effects: starts %0d busy %0d done %0d required 0 0 0",
                  obs_q.size(), busy_cnt, done_cnt);
      end
   endtask

   task automatic test_cfg_during_run();
      ldr_rand = 1'b0;
      build_exp(1);
      clear_obs();
      kick(1);
      repeat (3) @(negedge clk);
      #1;
      write_desc(0, 12'd9, 12'd2, 1'b1, 5'd3, 27'h100, 27'h200, 27'h300, 1'b0);
      wait_end(100, "cfg_during_run");
      drain_scoreboard("cfg_during_run", 2);
      clear_obs();
      kick(1);
      wait_end(100, "cfg_rerun");
      drain_scoreboard("cfg_rerun", 2);
   endtask

   task automatic test_write_with_start();
      // Entry 0 rewritten in the start cycle: the run uses the new data.
      clear_obs();
      cfg_idx = 4'd0; cfg_cin = 12'd7; cfg_cout = 12'd5; cfg_has_bias = 1'b0; cfg_act = 5'd9;
      cfg_in_addr = 27'h2100; cfg_w_addr = 27'h2200; cfg_out_addr = 27'h2300;
      m_cin[0] = 12'd7; m_cout[0] = 12'd5; m_bias[0] = 1'b0; m_act[0] = 5'd9;
      m_in[0] = 27'h2100; m_w[0] = 27'h2200; m_out[0] = 27'h2300;
      build_exp(2);
      cfg_we = 1'b1;
      kick(2);
      cfg_we = 1'b0;
      wait_end(300, "write_start_idx0");
      drain_scoreboard("write_start_idx0", 2);
      // Entry 1 rewritten in the start cycle: layer 0 needs a second read,
      // so the first LIF comes one cycle later.
      clear_obs();
      cfg_idx = 4'd1; cfg_cin = 12'd33; cfg_cout = 12'd44; cfg_has_bias = 1'b1; cfg_act = 5'd17;
      cfg_in_addr = 27'h3100; cfg_w_addr = 27'h3200; cfg_out_addr = 27'h3300;
      m_cin[1] = 12'd33; m_cout[1] = 12'd44; m_bias[1] = 1'b1; m_act[1] = 5'd17;
      m_in[1] = 27'h3100; m_w[1] = 27'h3200; m_out[1] = 27'h3300;
      build_exp(2);
      cfg_we = 1'b1;
      kick(2);
      cfg_we = 1'b0;
      wait_end(300, "write_start_idx1");
      drain_scoreboard("write_start_idx1", 3);
   endtask

   task automatic test_reset_mid_run();
      int k;
      ldr_rand = 1'b0;
      clear_obs();
      kick(1);
      k = 0;
      while (obs_q.size() < 2 && k < 50) begin
         @(negedge clk); #1;
         k++;
      end
      checks++;
      if (obs_q.size() < 2) begin
         errors++;
         $display("FAIL reset_mid_run reach LW: starts %0d required 2", obs_q.size());
      end
      @(negedge clk); #1;          // first WAIT_LW cycle
      rst = 1'b1;
      @(negedge clk); #1;
      checks++;
      if (all_outputs() !== '0) begin
         errors++;
         $display("FAIL reset_mid_run outputs: got %h required 0", all_outputs());
      end
      rst = 1'b0;
      repeat (10) @(negedge clk);
      #1;
      build_exp(1);
      clear_obs();
      kick(1);
      wait_end(100, "reset_restart");
      drain_scoreboard("reset_restart", 2);
   endtask

   task automatic test_max_layers();
      for (int i = 0; i < 16; i++) write_random(i);
      ldr_rand = 1'b1;
      build_exp(16);
      clear_obs();
      kick(16);
      wait_end(3000, "max_layers");
      drain_scoreboard("max_layers", 2);
   endtask

   task automatic test_random();
      int n;
      ldr_rand = 1'b1;
      for (int r = 0; r < 3; r++) begin
         n = $urandom_range(1, 5);
         for (int i = 0; i < n; i++) write_random(i);
         build_exp(n);
         clear_obs();
         kick(n);
         wait_end(1000, "random_run");
         drain_scoreboard("random_run", 2);
      end
      ldr_rand = 1'b0;
   endtask

`ifdef FC_SEQ_WDOG_EN
   task automatic test_wdog();
      int exp_c;
      ldr_on = 1'b0;
      clear_obs();
      kick(1);
      wait_end(200, "wdog");
      repeat (4) @(negedge clk);
      #1;
      // ISSUE_LIF at s, WAIT_LIF for 64 cycles, err in the cycle after.
      exp_c = (obs_cyc_q.size() > 0) ? obs_cyc_q[0] + 65 : -1;
      checks++;
      if (err_cnt != 1 || err_cyc != exp_c) begin
         errors++;
         $display("FAIL wdog err: count %0d cycle %0d required count 1 cycle %0d",
                  err_cnt, err_cyc, exp_c);
      end
      checks++;
      if (done_cnt != 0 || busy !== 1'b0 || obs_q.size() != 1) begin
         errors++;
         $display("FAIL wdog aftermath: done %0d busy %b starts %0d required 0 0 1",
                  done_cnt, busy, obs_q.size());
      end
      ldr_on = 1'b1;
   endtask
`endif

   // ---------------- sequence and report ----------------
   initial begin
      rst = 1'b1;
      cfg_we = 1'b0; cfg_idx = '0; cfg_cin = '0; cfg_cout = '0; cfg_has_bias = 1'b0;
      cfg_act = '0; cfg_in_addr = '0; cfg_w_addr = '0; cfg_out_addr = '0;
      num_layers = '0; start = 1'b0;
      clear_obs();
      start_cyc = 0;
      test_reset();
      test_two_layers();
      test_empty_run();
      test_too_many();
      test_cfg_during_run();
      test_write_with_start();
      test_reset_mid_run();
      test_max_layers();
      test_random();
`ifdef FC_SEQ_WDOG_EN
      test_wdog();
`endif
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: simulation did not finish in time");
      $fatal(1, "timeout");
   end

endmodule
